alu_exec_stage: RTL

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
// ALU execute stage: add/sub and accumulator ops through a shared adder,
// with results queued in a 2-entry in-order output FIFO.

module addsub32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    logic [WIDTH:0] sum;

    // Subtract as a + ~b + 1 so carry-out means "no borrow"
    assign sum = {1'b0, a}
               + {1'b0, b ^ {WIDTH{sub}}}
               + {{WIDTH{1'b0}}, sub};
    assign s   = sum[WIDTH-1:0];
    assign co  = sum[WIDTH];

endmodule

module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic [3:0]       out_flags,
    output logic [WIDTH-1:0] acc_q
);

    localparam int M = WIDTH - 1;

    logic [1:0][WIDTH-1:0] mem_s_q, mem_s_d;
    logic [1:0][3:0]       mem_f_q, mem_f_d;
    logic [1:0]            count_q, count_d;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic                  in_ready_q, in_ready_d;
    logic [WIDTH-1:0]      acc_d;

    logic [WIDTH-1:0] acc_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] add_s;
    logic             add_co;
    logic             ovf;
    logic [3:0]       flags;
    logic             push;
    logic             pop;

    // Select adder operands; a same-edge clear makes the acc operand zero
    always_comb begin
        acc_op = acc_clr ? '0 : acc_q;
        op_a   = in_op[1] ? acc_op : in_a;
        op_b   = in_op[1] ? in_a : in_b;
    end

    addsub32 #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a  (op_a),
        .b  (op_b),
        .sub(in_op[0]),
        .s  (add_s),
        .co (add_co)
    );

    // Flags: signed overflow depends on add/sub operand sign agreement
    always_comb begin
        if (in_op[0]) begin
            ovf = (op_a[M] != op_b[M]) && (add_s[M] != op_a[M]);
        end else begin
            ovf = (op_a[M] == op_b[M]) && (add_s[M] != op_a[M]);
        end
        flags = {add_s[M], (add_s == '0), add_co, ovf};
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_s     = out_valid ? mem_s_q[rd_q] : '0;
    assign out_flags = out_valid ? mem_f_q[rd_q] : 4'd0;
    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    // Next-state for FIFO, accumulator and registered ready
    always_comb begin
        mem_s_d = mem_s_q;
        mem_f_d = mem_f_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        acc_d   = acc_q;
        if (push) begin
            mem_s_d[wr_q] = add_s;
            mem_f_d[wr_q] = flags;
            wr_d          = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (push && in_op[1]) begin
            acc_d = add_s;
        end else if (acc_clr) begin
            acc_d = '0;
        end
        in_ready_d = (count_d < 2'd2);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_s_q    <= '0;
            mem_f_q    <= '0;
            count_q    <= 2'd0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            mem_s_q    <= mem_s_d;
            mem_f_q    <= mem_f_d;
            count_q    <= count_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            acc_q      <= acc_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule
